// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse keyer front end and the downstream letter
// decoder.
//   - dotdash encodings: DD_NONE, DD_DOT, DD_DASH
//   - keyer_state_e    : keyer FSM state encoding
//   - TICK_W / TICK_MAX: width and saturation value of tick counters
//   - sat_inc          : saturating tick-counter increment
//   - cnt_width        : counter width able to hold 0..n-1 (minimum 1 bit)
// -----------------------------------------------------------------------------
package morse_pkg;

  localparam int TICK_W = 10;
  localparam logic [TICK_W-1:0] TICK_MAX = 10'd1023;

  localparam logic [1:0] DD_NONE = 2'b00;
  localparam logic [1:0] DD_DOT  = 2'b10;
  localparam logic [1:0] DD_DASH = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PRESS = 2'b01,
    ST_GAP   = 2'b10
  } keyer_state_e;

  // Increment that sticks at TICK_MAX instead of wrapping to zero.
  function automatic logic [TICK_W-1:0] sat_inc(input logic [TICK_W-1:0] v);
    logic [TICK_W-1:0] r;
    if (v == TICK_MAX) begin
      r = v;
    end else begin
      r = v + 10'd1;
    end
    return r;
  endfunction

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    int r;
    if (n > 1) begin
      r = $clog2(n);
    end else begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/morse_debounce.sv
// -----------------------------------------------------------------------------
// morse_debounce
// Two-flop synchroniser followed by a stability-counter debouncer for the raw
// active-low key. key_db only changes after the synchronised level has differed
// from it for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clock50 : system clock
//   reset   : asynchronous active-low reset
//   in      : raw key (0 = pressed), asynchronous to clock50
//   key_db  : debounced key level (0 = pressed), resets to released
// -----------------------------------------------------------------------------
module morse_debounce
  import morse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock50,
  input  logic reset,
  input  logic in,
  output logic key_db
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          key_db_q, key_db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state for synchroniser and stability counter.
  always_comb begin
    sync1_d  = in;
    sync2_d  = sync1_q;
    key_db_d = key_db_q;
    cnt_d    = cnt_q;
    if (sync2_q == key_db_q) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q == CNT_LAST) begin
      // Level has been different long enough: accept it.
      key_db_d = sync2_q;
      cnt_d    = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State registers; the key resets to the released level.
  always_ff @(posedge clock50 or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      key_db_q <= 1'b1;
      cnt_q    <= CNT_ZERO;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      key_db_q <= key_db_d;
      cnt_q    <= cnt_d;
    end
  end

  assign key_db = key_db_q;

endmodule

// File: rtl/morse_keyer.sv
// -----------------------------------------------------------------------------
// morse_keyer
// Front end of the Morse decoder: debounces the key, times each press in
// prescaled ticks and classifies it as a dot or dash.
// Optional feature macro: MORSE_LETTER_GAP_EN adds the GAP state, the gap tick
// counter and the letter_end strobe; without it a symbol returns to IDLE and
// letter_end is tied low (GAP_TICKS is then unused).
// Ports:
//   clock50     : system clock
//   reset       : asynchronous active-low reset
//   in          : raw key, active-low, asynchronous
//   sym_valid   : one-cycle strobe, symbol classified
//   sym         : 0 = dot, 1 = dash (qualified by sym_valid)
//   dotdash     : last symbol held (10 dot, 01 dash, 00 none)
//   pressing    : debounced key is down
//   press_ticks : ticks of the current/last press, saturating at 1023
//   letter_end  : one-cycle strobe, inter-letter gap elapsed
// -----------------------------------------------------------------------------
module morse_keyer
  import morse_pkg::*;
#(
  parameter int DIVIDE          = 6250000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DASH_TICKS      = 5,
  parameter int GAP_TICKS       = 10
) (
  input  logic              clock50,
  input  logic              reset,
  input  logic              in,
  output logic              sym_valid,
  output logic              sym,
  output logic [1:0]        dotdash,
  output logic              pressing,
  output logic [TICK_W-1:0] press_ticks,
  output logic              letter_end
);

  localparam int PW = cnt_width(DIVIDE);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIVIDE - 1);
  localparam logic [PW-1:0] PRESC_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [TICK_W-1:0] DASH_LIMIT = TICK_W'(DASH_TICKS);

  logic key_db;

  morse_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock50(clock50),
    .reset  (reset),
    .in     (in),
    .key_db (key_db)
  );

  logic              key_prev_q, key_prev_d;
  logic [PW-1:0]     presc_q, presc_d;
  keyer_state_e      state_q, state_d;
  keyer_state_e      ret_q, ret_d;
  logic [TICK_W-1:0] press_ticks_q, press_ticks_d;
  logic              sym_valid_q, sym_valid_d;
  logic              sym_q, sym_d;
  logic [1:0]        dotdash_q, dotdash_d;
  logic              pressing_q, pressing_d;
  logic              press_edge, release_edge, tick;
  logic [TICK_W-1:0] ticks_inc;
  logic              is_dash;
`ifdef MORSE_LETTER_GAP_EN
  localparam logic [TICK_W-1:0] GAP_LIMIT = TICK_W'(GAP_TICKS);
  logic [TICK_W-1:0] gap_ticks_q, gap_ticks_d;
  logic              letter_end_q, letter_end_d;
`endif

  // Debounced edges and prescaler; the prescaler restarts on every edge so the
  // first tick always lands a full DIVIDE period after it.
  always_comb begin
    key_prev_d   = key_db;
    press_edge   = key_prev_q & ~key_db;
    release_edge = ~key_prev_q & key_db;
    tick         = (presc_q == PRESC_LAST);
    if (press_edge || release_edge || tick) begin
      presc_d = PRESC_ZERO;
    end else begin
      presc_d = presc_q + PRESC_ONE;
    end
  end

  // Keyer FSM next-state and registered-output values.
  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    press_ticks_d = press_ticks_q;
    sym_valid_d   = 1'b0;
    sym_d         = 1'b0;
    dotdash_d     = dotdash_q;
    pressing_d    = ~key_db;
    // A tick coinciding with release is counted before classification.
    if (tick) begin
      ticks_inc = sat_inc(press_ticks_q);
    end else begin
      ticks_inc = press_ticks_q;
    end
    is_dash = (ticks_inc >= DASH_LIMIT);
`ifdef MORSE_LETTER_GAP_EN
    gap_ticks_d  = gap_ticks_q;
    letter_end_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (press_edge) begin
          state_d       = ST_PRESS;
          ret_d         = ST_IDLE;
          press_ticks_d = {TICK_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRESS: begin
        press_ticks_d = ticks_inc;
        if (release_edge) begin
          if (ticks_inc == {TICK_W{1'b0}}) begin
            // Too short to be a symbol: resume whatever we were doing.
            state_d = ret_q;
          end else begin
            sym_valid_d = 1'b1;
            sym_d       = is_dash;
            dotdash_d   = is_dash ? DD_DASH : DD_DOT;
`ifdef MORSE_LETTER_GAP_EN
            state_d     = ST_GAP;
            gap_ticks_d = {TICK_W{1'b0}};
`else
            state_d     = ST_IDLE;
`endif
          end
        end else begin
          state_d = ST_PRESS;
        end
      end
`ifdef MORSE_LETTER_GAP_EN
      ST_GAP: begin
        if (press_edge) begin
          state_d       = ST_PRESS;
          ret_d         = ST_GAP;
          press_ticks_d = {TICK_W{1'b0}};
          gap_ticks_d   = {TICK_W{1'b0}};
        end else if (tick) begin
          if ((gap_ticks_q + 10'd1) == GAP_LIMIT) begin
            letter_end_d = 1'b1;
            state_d      = ST_IDLE;
            gap_ticks_d  = {TICK_W{1'b0}};
          end else begin
            gap_ticks_d = gap_ticks_q + 10'd1;
          end
        end else begin
          state_d = ST_GAP;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        ret_d   = ST_IDLE;
      end
    endcase
  end

  // Keyer state and output registers.
  always_ff @(posedge clock50 or negedge reset) begin
    if (!reset) begin
      key_prev_q    <= 1'b1;
      presc_q       <= PRESC_ZERO;
      state_q       <= ST_IDLE;
      ret_q         <= ST_IDLE;
      press_ticks_q <= {TICK_W{1'b0}};
      sym_valid_q   <= 1'b0;
      sym_q         <= 1'b0;
      dotdash_q     <= DD_NONE;
      pressing_q    <= 1'b0;
    end else begin
      key_prev_q    <= key_prev_d;
      presc_q       <= presc_d;
      state_q       <= state_d;
      ret_q         <= ret_d;
      press_ticks_q <= press_ticks_d;
      sym_valid_q   <= sym_valid_d;
      sym_q         <= sym_d;
      dotdash_q     <= dotdash_d;
      pressing_q    <= pressing_d;
    end
  end

`ifdef MORSE_LETTER_GAP_EN
  // Gap counter and letter_end strobe registers.
  always_ff @(posedge clock50 or negedge reset) begin
    if (!reset) begin
      gap_ticks_q  <= {TICK_W{1'b0}};
      letter_end_q <= 1'b0;
    end else begin
      gap_ticks_q  <= gap_ticks_d;
      letter_end_q <= letter_end_d;
    end
  end

  assign letter_end = letter_end_q;
`else
  assign letter_end = 1'b0;
`endif

  assign sym_valid   = sym_valid_q;
  assign sym         = sym_q;
  assign dotdash     = dotdash_q;
  assign pressing    = pressing_q;
  assign press_ticks = press_ticks_q;

endmodule

// File: tb/tb_morse_keyer.sv
// -----------------------------------------------------------------------------
// tb_morse_keyer
// Self-checking bench for morse_keyer with DIVIDE=4, DEBOUNCE_CYCLES=3,
// DASH_TICKS=5, GAP_TICKS=10. A key held low for L cycles yields
// press_ticks = L/4 (integer division) when L >= 3.
// -----------------------------------------------------------------------------
module tb_morse_keyer;
  import morse_pkg::*;

`ifdef MORSE_LETTER_GAP_EN
  localparam int GAP_EN = 1;
`else
  localparam int GAP_EN = 0;
`endif

  logic        clock50 = 1'b0;
  logic        reset;
  logic        in;
  logic        sym_valid;
  logic        sym;
  logic [1:0]  dotdash;
  logic        pressing;
  logic [9:0]  press_ticks;
  logic        letter_end;

  always #5 clock50 = ~clock50;

  morse_keyer #(
    .DIVIDE(4),
    .DEBOUNCE_CYCLES(3),
    .DASH_TICKS(5),
    .GAP_TICKS(10)
  ) dut (
    .clock50    (clock50),
    .reset      (reset),
    .in         (in),
    .sym_valid  (sym_valid),
    .sym        (sym),
    .dotdash    (dotdash),
    .pressing   (pressing),
    .press_ticks(press_ticks),
    .letter_end (letter_end)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Monitor state, sampled on the falling edge.
  int   sym_cnt  = 0;
  int   le_cnt   = 0;
  int   overlap  = 0;
  int   sym_cyc  = 0;
  int   le_cyc   = 0;
  logic last_sym = 1'b0;
  bit   saw_press = 1'b0;

  always @(posedge clock50) cyc <= cyc + 1;

  always @(negedge clock50) begin
    if (sym_valid === 1'b1) begin
      sym_cnt  = sym_cnt + 1;
      last_sym = sym;
      sym_cyc  = cyc;
    end
    if (letter_end === 1'b1) begin
      le_cnt = le_cnt + 1;
      le_cyc = cyc;
    end
    if (sym_valid === 1'b1 && letter_end === 1'b1) overlap = overlap + 1;
    if (pressing === 1'b1) saw_press = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock50);
    #1;
  endtask

  typedef struct {
    int         low_len;
    int         n_sym;
    logic       exp_sym;
    logic [1:0] exp_dd;
    int         exp_ticks;
  } vec_t;

  vec_t vecs[7];
  int   s0, l0, c_rel;

  initial begin
    // {key low cycles, symbols, sym, dotdash after, press_ticks after}
    vecs[0] = '{12,   1, 1'b0, 2'b10, 3};     // dot, tick and release coincide
    vecs[1] = '{20,   1, 1'b1, 2'b01, 5};     // exactly DASH_TICKS -> dash
    vecs[2] = '{19,   1, 1'b0, 2'b10, 4};     // one tick short -> dot
    vecs[3] = '{3,    0, 1'b0, 2'b10, 0};     // debounced but zero ticks: glitch
    vecs[4] = '{4,    1, 1'b0, 2'b10, 1};     // shortest dot
    vecs[5] = '{4200, 1, 1'b1, 2'b01, 1023};  // saturated count, still dash
    vecs[6] = '{7,    1, 1'b0, 2'b10, 1};

    // Reset held with key toggling: every output stays at zero.
    reset = 1'b0;
    in    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in = ~in;
      step(1);
      check("reset_outputs",
            {17'd0, sym_valid, sym, dotdash, pressing, press_ticks, letter_end}, 32'd0);
    end
    in = 1'b1;
    step(2);
    reset = 1'b1;
    step(20);
    check("reset_release_sym", sym_cnt, 0);
    check("reset_release_le", le_cnt, 0);
    check("reset_release_dd", dotdash, 2'b00);

    // Bounce: 2-cycle low pulses never satisfy the 3-cycle debounce.
    saw_press = 1'b0;
    s0 = sym_cnt;
    for (int i = 0; i < 3; i++) begin
      in = 1'b0;
      step(2);
      in = 1'b1;
      step(1);
    end
    step(20);
    check("bounce_pressing", saw_press, 0);
    check("bounce_sym", sym_cnt - s0, 0);

    // Reset during a press at tick 3: nothing is emitted afterwards.
    s0 = sym_cnt;
    in = 1'b0;
    step(18);
    check("midpress_ticks", press_ticks, 3);
    check("midpress_pressing", pressing, 1);
    reset = 1'b0;
    in    = 1'b1;
    step(3);
    check("midpress_reset_outputs",
          {17'd0, sym_valid, sym, dotdash, pressing, press_ticks, letter_end}, 32'd0);
    reset = 1'b1;
    step(60);
    check("midpress_sym", sym_cnt - s0, 0);
    check("midpress_dd", dotdash, 2'b00);

    // Table of single presses, each followed by a long release.
    for (int i = 0; i < 7; i++) begin
      s0 = sym_cnt;
      l0 = le_cnt;
      in = 1'b0;
      step(vecs[i].low_len);
      in = 1'b1;
      step(60);
      check($sformatf("vec%0d_nsym", i), sym_cnt - s0, vecs[i].n_sym);
      if (vecs[i].n_sym == 1) check($sformatf("vec%0d_sym", i), last_sym, vecs[i].exp_sym);
      check($sformatf("vec%0d_dd", i), dotdash, vecs[i].exp_dd);
      check($sformatf("vec%0d_ticks", i), press_ticks, vecs[i].exp_ticks);
      check($sformatf("vec%0d_pressing", i), pressing, 0);
      check($sformatf("vec%0d_le", i), le_cnt - l0, GAP_EN * vecs[i].n_sym);
    end

    // Latency of sym_valid from raw release, and letter_end timing.
    s0 = sym_cnt;
    l0 = le_cnt;
    in = 1'b0;
    step(12);
    c_rel = cyc;
    in = 1'b1;
    step(60);
    check("lat_nsym", sym_cnt - s0, 1);
    check("lat_sym_cycles", sym_cyc - c_rel, 6);
    check("lat_le_count", le_cnt - l0, GAP_EN);
`ifdef MORSE_LETTER_GAP_EN
    check("lat_le_after_sym", le_cyc - sym_cyc, 40);
`endif

    // New press lands on the 9th gap tick: no letter_end, next symbol emitted.
    s0 = sym_cnt;
    l0 = le_cnt;
    in = 1'b0;
    step(12);
    in = 1'b1;
    step(36);
    in = 1'b0;
    step(20);
    in = 1'b1;
    step(8);
    check("gap9_nsym", sym_cnt - s0, 2);
    check("gap9_le", le_cnt - l0, 0);
    check("gap9_sym", last_sym, 1'b1);
    check("gap9_dd", dotdash, 2'b01);
    step(60);
    check("gap9_le_final", le_cnt - l0, GAP_EN);

    check("strobe_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
